// File: rtl/fixed_pkg.sv
// Shared fixed-point helpers: signed saturation bounds, rounding bias and
// parameter legality for the round/saturate datapath.
package fixed_pkg;

  // Largest value representable in a signed field of the given width.
  function automatic logic signed [63:0] sat_max(input int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a signed field of the given width.
  function automatic logic signed [63:0] sat_min(input int unsigned width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  // Half of one output LSB, expressed in input LSBs.
  function automatic logic signed [63:0] round_bias(input int unsigned shift);
    return (shift == 0) ? 64'sd0 : (64'sd1 <<< (shift - 1));
  endfunction

  function automatic bit shift_legal(input int unsigned in_width,
                                     input int unsigned in_frac_width,
                                     input int unsigned out_width,
                                     input int unsigned out_frac_width);
    return (in_frac_width >= out_frac_width) && (in_width >= out_width);
  endfunction

endpackage

// File: rtl/fixed_saturate.sv
// Combinational signed clamp from IN_WIDTH down to OUT_WIDTH, with a flag
// raised whenever the result was clamped.
module fixed_saturate
  import fixed_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 35,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic signed [IN_WIDTH-1:0]  sum,
  output logic signed [OUT_WIDTH-1:0] value,
  output logic                        clamped
);

  localparam logic signed [IN_WIDTH-1:0] MaxVal = IN_WIDTH'(sat_max(OUT_WIDTH));
  localparam logic signed [IN_WIDTH-1:0] MinVal = IN_WIDTH'(sat_min(OUT_WIDTH));

  always_comb begin
    value   = sum[OUT_WIDTH-1:0];
    clamped = 1'b0;
    if (sum > MaxVal) begin
      value   = MaxVal[OUT_WIDTH-1:0];
      clamped = 1'b1;
    end else if (sum < MinVal) begin
      value   = MinVal[OUT_WIDTH-1:0];
      clamped = 1'b1;
    end
  end

endmodule

// File: rtl/fixed_round_saturate_pipe.sv
// Two-stage valid/ready rescaler: S1 biases and arithmetically shifts, S2 saturates.
// Define FIXED_ROUND_SATURATE_PIPE_ROUND_EN for round-half-up; default truncates.
module fixed_round_saturate_pipe
  import fixed_pkg::*;
#(
  parameter int unsigned IN_WIDTH       = 34,
  parameter int unsigned IN_FRAC_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH      = 16,
  parameter int unsigned OUT_FRAC_WIDTH = 4,
  parameter int unsigned SAT_CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  data_in,
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic signed [OUT_WIDTH-1:0] data_out,
  output logic                        data_out_valid,
  input  logic                        data_out_ready,
  output logic [SAT_CNT_WIDTH-1:0]    sat_count
);

  localparam int unsigned S1Width = IN_WIDTH + 1;
  localparam int unsigned Shift   = (IN_FRAC_WIDTH >= OUT_FRAC_WIDTH) ?
                                    IN_FRAC_WIDTH - OUT_FRAC_WIDTH : 0;

  if (!shift_legal(IN_WIDTH, IN_FRAC_WIDTH, OUT_WIDTH, OUT_FRAC_WIDTH)) begin : g_param_check
    $error("fixed_round_saturate_pipe: need IN_FRAC_WIDTH >= OUT_FRAC_WIDTH and IN_WIDTH >= OUT_WIDTH");
  end

`ifdef FIXED_ROUND_SATURATE_PIPE_ROUND_EN
  localparam logic signed [S1Width-1:0] Bias = S1Width'(round_bias(Shift));
`else
  localparam logic signed [S1Width-1:0] Bias = '0;
`endif

  logic                        s1_valid;
  logic signed [S1Width-1:0]   s1_data;
  logic signed [S1Width-1:0]   s1_ext;
  logic signed [S1Width-1:0]   s1_next;
  logic signed [OUT_WIDTH-1:0] sat_value;
  logic                        sat_clamped;
  logic                        out_clamped;
  logic                        s2_can_load;
  logic                        out_fire;

  assign s2_can_load   = !data_out_valid || data_out_ready;
  assign data_in_ready = !s1_valid || s2_can_load;
  assign out_fire      = data_out_valid && data_out_ready;

  // One extra bit keeps the bias add from overflowing at the positive limit.
  always_comb begin
    s1_ext  = {data_in[IN_WIDTH-1], data_in};
    s1_next = (s1_ext + Bias) >>> Shift;
  end

  fixed_saturate #(
    .IN_WIDTH  (S1Width),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_saturate (
    .sum     (s1_data),
    .value   (sat_value),
    .clamped (sat_clamped)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid       <= 1'b0;
      s1_data        <= '0;
      data_out_valid <= 1'b0;
      data_out       <= '0;
      out_clamped    <= 1'b0;
      sat_count      <= '0;
    end else begin
      if (data_in_ready) begin
        s1_valid <= data_in_valid;
        if (data_in_valid) begin
          s1_data <= s1_next;
        end
      end
      if (s2_can_load) begin
        data_out_valid <= s1_valid;
        if (s1_valid) begin
          data_out    <= sat_value;
          out_clamped <= sat_clamped;
        end
      end
      // Count clamped results as they leave, sticking at all-ones.
      if (out_fire && out_clamped && (sat_count != {SAT_CNT_WIDTH{1'b1}})) begin
        sat_count <= sat_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fixed_round_saturate_pipe.sv
// Directed bench for fixed_round_saturate_pipe at IN 8.4 -> OUT 4.2 (shift of 2).
module tb_fixed_round_saturate_pipe;

  logic              clk;
  logic              rst;
  logic signed [7:0] data_in;
  logic              data_in_valid;
  logic              data_in_ready;
  logic signed [3:0] data_out;
  logic              data_out_valid;
  logic              data_out_ready;
  logic [7:0]        sat_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int outq[$];
  int out_times[$];

`ifdef FIXED_ROUND_SATURATE_PIPE_ROUND_EN
  localparam int Bias = 2;
  localparam int ExpPos6 = 2;
  localparam int ExpNeg6 = -1;
`else
  localparam int Bias = 0;
  localparam int ExpPos6 = 1;
  localparam int ExpNeg6 = -2;
`endif

  fixed_round_saturate_pipe #(
    .IN_WIDTH       (8),
    .IN_FRAC_WIDTH  (4),
    .OUT_WIDTH      (4),
    .OUT_FRAC_WIDTH (2),
    .SAT_CNT_WIDTH  (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .sat_count      (sat_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output transfer mid-cycle, when inputs and outputs are settled.
  always @(negedge clk) begin
    if (!rst && data_out_valid && data_out_ready) begin
      outq.push_back(int'(data_out));
      out_times.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model(input int x);
    int y;
    y = (x + Bias) >>> 2;
    if (y > 7) y = 7;
    if (y < -8) y = -8;
    return y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one item and hold it until it is accepted (bounded wait).
  task automatic push(input int v);
    int guard;
    data_in       = 8'(v);
    data_in_valid = 1'b1;
    guard         = 0;
    @(negedge clk);
    while (!data_in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_val("push_ready", int'(data_in_ready), 1);
    tick();
  endtask

  task automatic wait_outputs(input int n);
    int guard;
    guard = 0;
    while (outq.size() < n && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) tick();
  endtask

  task automatic single(input string tag, input int x, input int exp);
    data_in       = 8'(x);
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    check_val({tag, "_valid_early"}, int'(data_out_valid), 0);
    tick();
    check_val({tag, "_valid_lat2"}, int'(data_out_valid), 1);
    check_val({tag, "_value"}, int'(data_out), exp);
    repeat (3) tick();
  endtask

  initial begin
    bit stall_ok;
    bit saw_ready_low;
    int ref_out;
    int bad;

    rst            = 1'b1;
    data_in        = '0;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_val("rst_out_valid", int'(data_out_valid), 0);
    check_val("rst_data_out", int'(data_out), 0);
    check_val("rst_sat_count", int'(sat_count), 0);
    check_val("rst_in_ready", int'(data_in_ready), 1);

    single("pos6", 6, ExpPos6);
    single("neg6", -6, ExpNeg6);

    // Saturation both ways, back to back.
    data_in       = 8'sd100;
    data_in_valid = 1'b1;
    tick();
    data_in       = -8'sd100;
    tick();
    data_in_valid = 1'b0;
    check_val("sat_hi_value", int'(data_out), 7);
    tick();
    check_val("sat_lo_value", int'(data_out), -8);
    tick();
    check_val("sat_count_2", int'(sat_count), 2);
    repeat (2) tick();

    // Stream 1..20 with a 5-cycle output stall.
    outq.delete();
    stall_ok      = 1'b1;
    saw_ready_low = 1'b0;
    fork
      begin
        for (int i = 1; i <= 20; i++) push(i);
        data_in_valid = 1'b0;
      end
      begin
        repeat (6) tick();
        data_out_ready = 1'b0;
        ref_out        = int'(data_out);
        repeat (5) begin
          @(negedge clk);
          if (int'(data_out) != ref_out || !data_out_valid) stall_ok = 1'b0;
          if (!data_in_ready) saw_ready_low = 1'b1;
          tick();
        end
        data_out_ready = 1'b1;
      end
    join
    wait_outputs(20);
    check_val("stream_count", outq.size(), 20);
    for (int i = 0; i < 20 && i < outq.size(); i++) begin
      check_val($sformatf("stream_item%0d", i + 1), outq[i], model(i + 1));
    end
    check_val("stall_stable", int'(stall_ok), 1);
    check_val("stall_in_ready_low", int'(saw_ready_low), 1);

    // Reset with two items in flight.
    outq.delete();
    data_in       = 8'sd40;
    data_in_valid = 1'b1;
    tick();
    data_in       = 8'sd44;
    tick();
    data_in_valid = 1'b0;
    rst           = 1'b1;
    tick();
    rst = 1'b0;
    check_val("midrst_in_ready", int'(data_in_ready), 1);
    check_val("midrst_out_valid", int'(data_out_valid), 0);
    check_val("midrst_sat_count", int'(sat_count), 0);
    repeat (5) tick();
    check_val("midrst_no_output", outq.size(), 0);

    // 255 saturating inputs back to back, then more to test the sticky counter.
    outq.delete();
    out_times.delete();
    for (int i = 0; i < 255; i++) push(100);
    data_in_valid = 1'b0;
    wait_outputs(255);
    check_val("burst_count", outq.size(), 255);
    bad = 0;
    foreach (outq[i]) if (outq[i] != 7) bad++;
    check_val("burst_values_not7", bad, 0);
    if (out_times.size() >= 255) begin
      check_val("burst_one_per_cycle", out_times[254] - out_times[0], 254);
    end else begin
      check_val("burst_times_size", out_times.size(), 255);
    end
    check_val("sat_count_255", int'(sat_count), 255);
    for (int i = 0; i < 3; i++) push(100);
    data_in_valid = 1'b0;
    wait_outputs(258);
    check_val("burst_extra_count", outq.size(), 258);
    check_val("sat_count_sticky", int'(sat_count), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_round_saturate_pipe.md
FIXED_ROUND_SATURATE_PIPE -- requirements
Module: fixed_round_saturate_pipe

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- IN_WIDTH, 34, signed input width (accumulator sum width).
- IN_FRAC_WIDTH, 8, input fractional bits.
- OUT_WIDTH, 16, signed output width.
- OUT_FRAC_WIDTH, 4, output fractional bits.
- SAT_CNT_WIDTH, 16, saturation event counter width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- data_in, in, IN_WIDTH, signed two's-complement sum.
- data_in_valid, in, 1, input valid.
- data_in_ready, out, 1, input ready.
- data_out, out, OUT_WIDTH, signed rescaled result.
- data_out_valid, out, 1, output valid.
- data_out_ready, in, 1, output ready.
- sat_count, out, SAT_CNT_WIDTH, number of saturated results emitted.
REQ-003 The block SHALL have one clock (clk) and a synchronous, active-high reset (rst).

Function
REQ-004 SHIFT = IN_FRAC_WIDTH - OUT_FRAC_WIDTH SHALL be >= 0 and IN_WIDTH SHALL be >= OUT_WIDTH; an elaboration-time check SHALL fail otherwise.
REQ-005 A transfer SHALL occur on a rising edge when valid and ready are both high, on each side independently.
REQ-006 The pipeline SHALL be two registered stages:
- S1 registers the biased, arithmetically right-shifted value in IN_WIDTH+1 bits.
- S2 registers the saturated OUT_WIDTH result, which drives data_out.
REQ-007 Latency from an accepted input to data_out_valid SHALL be exactly 2 cycles when not stalled.
REQ-008 Each stage SHALL load when it is empty or when its content moves downstream in the same cycle.
- data_in_ready SHALL equal !s1_valid || s2_can_load.
- s2_can_load SHALL equal !data_out_valid || data_out_ready.
REQ-009 With no backpressure, the block SHALL sustain one result per cycle.
REQ-010 data_out and data_out_valid SHALL hold stable while data_out_valid is high and data_out_ready is low.
REQ-011 Saturation SHALL clamp to 2^(OUT_WIDTH-1)-1 when above that value and to -2^(OUT_WIDTH-1) when below that value; otherwise the low OUT_WIDTH bits SHALL pass through.
REQ-012 When SHIFT = 0, the bias SHALL be 0 and S1 SHALL pass the sign-extended input unchanged.
REQ-013 sat_count SHALL increment by 1 on each output transfer whose value was clamped, and SHALL stick at all-ones rather than wrap.
REQ-014 Simultaneous input accept, S1 to S2 move and output transfer in one cycle SHALL lose and duplicate no data.

Reset
REQ-015 While rst is high, s1_valid, data_out_valid and sat_count SHALL be cleared to 0 at the next edge; data_out SHALL reset to 0.
REQ-016 Reset asserted mid-stream SHALL discard all in-flight data, and data_in_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-017 When FIXED_ROUND_SATURATE_PIPE_ROUND_EN is defined, S1 SHALL add the bias 2^(SHIFT-1) before the arithmetic shift (round half up toward +inf).
REQ-018 When FIXED_ROUND_SATURATE_PIPE_ROUND_EN is undefined, S1 SHALL shift with no bias (truncate toward -inf), and latency SHALL be unchanged.

Structure
REQ-019 A shared package fixed_pkg SHALL hold the saturation-bound helper functions (max/min signed for a given width) and the SHIFT-legality check function.
REQ-020 The saturation clamp SHALL be a sub-module fixed_saturate (purely combinational; params IN_WIDTH, OUT_WIDTH; outputs value and a clamped flag), instantiated once before S2.

Verification
Parameters for all scenarios: IN_WIDTH=8, IN_FRAC_WIDTH=4, OUT_WIDTH=4, OUT_FRAC_WIDTH=2, so SHIFT=2.
REQ-021 Input 6 -> data_out 2 with ROUND_EN, 1 without; data_out_valid 2 cycles after accept.
REQ-022 Input -6 -> data_out -1 with ROUND_EN, -2 without.
REQ-023 Inputs 100 then -100 -> data_out 7 then -8, sat_count 2.
REQ-024 Stream 1..20 with data_out_ready low for 5 cycles mid-stream -> all 20 results in order, data_out stable while stalled, data_in_ready low once both stages are full.
REQ-025 rst pulsed with 2 items in flight -> no output after reset, sat_count 0, data_in_ready 1 on the next cycle.
REQ-026 Back-to-back 255 inputs of 100 with ready always high -> one output per cycle, sat_count 255 then stays at 255 for additional inputs when SAT_CNT_WIDTH=8.
